// File: rtl/registro_pkg.sv
// Shared sizing defaults and board-cell encodings for the register bank.
package registro_pkg;

    localparam int ANCHO_DEF   = 6;
    localparam int CANALES_DEF = 9;

    typedef enum logic [ANCHO_DEF-1:0] {
        VACIO     = 6'd0,
        JUGADOR_X = 6'd1,
        JUGADOR_O = 6'd2
    } celda_t;

endpackage

// File: rtl/registro_banco_if.sv
// Addressed write port of the register bank with its accept/reject response.
interface registro_banco_if
    import registro_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int CANALES = CANALES_DEF
);
    localparam int SW = $clog2(CANALES);

    logic          wr_en;
    logic [SW-1:0] wr_sel;
    logic [ANCHO-1:0] wr_data;
    logic          ack;
    logic          nack;

    modport master (
        output wr_en, wr_sel, wr_data,
        input  ack, nack
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        output ack, nack
    );

endinterface

// File: rtl/registro_celda.sv
// One bank channel: an ANCHO-bit word plus its written flag, optionally write-once.
module registro_celda
    import registro_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic             lock,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q,
    output logic             ocupado
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            q       <= '0;
            ocupado <= 1'b0;
        end else if (we && !(lock && ocupado)) begin
            q       <= d;
            ocupado <= 1'b1;
        end
    end

endmodule

// File: rtl/registro_banco.sv
// Multi-channel register bank with occupancy count and ack/nack per write.
// Build option: define REGISTRO_BANCO_LOCK_EN to make every channel write-once until cleared.
module registro_banco
    import registro_pkg::*;
#(
    parameter  int ANCHO   = ANCHO_DEF,
    parameter  int CANALES = CANALES_DEF,
    localparam int SW      = $clog2(CANALES),
    localparam int CW      = $clog2(CANALES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    registro_banco_if.slave          bus,
    output logic [CANALES*ANCHO-1:0] salida,
    output logic [CANALES-1:0]       ocupado,
    output logic [CW-1:0]            cuenta,
    output logic                     lleno
);

`ifdef REGISTRO_BANCO_LOCK_EN
    localparam logic LOCK = 1'b1;
`else
    localparam logic LOCK = 1'b0;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c == CW'(CANALES))
            return c;
        return c + 1'b1;
    endfunction

    logic               sel_ok;
    logic               sel_ocupado;
    logic               acepta;
    logic               nuevo;
    logic [CANALES-1:0] we;
    logic               ack_p1;
    logic               nack_p1;
    logic [CW-1:0]      cuenta_p1;

    // stage p0: address decode and accept decision from registered occupancy
    always_comb begin
        sel_ok      = int'(bus.wr_sel) < CANALES;
        sel_ocupado = 1'b0;
        we          = '0;
        for (int i = 0; i < CANALES; i++) begin
            if (bus.wr_sel == SW'(i))
                sel_ocupado = ocupado[i];
        end
        acepta = bus.wr_en && sel_ok && !(LOCK && sel_ocupado);
        nuevo  = acepta && !sel_ocupado;
        for (int i = 0; i < CANALES; i++) begin
            we[i] = acepta && (bus.wr_sel == SW'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < CANALES; g++) begin : g_celda
            registro_celda #(.ANCHO(ANCHO)) u_celda (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .we      (we[g]),
                .lock    (LOCK),
                .d       (bus.wr_data),
                .q       (salida[g*ANCHO +: ANCHO]),
                .ocupado (ocupado[g])
            );
        end
    endgenerate

    // stage p1: response pulses and occupancy count
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ack_p1    <= 1'b0;
            nack_p1   <= 1'b0;
            cuenta_p1 <= '0;
        end else begin
            ack_p1  <= acepta;
            nack_p1 <= bus.wr_en && !acepta;
            if (nuevo)
                cuenta_p1 <= sat_inc(cuenta_p1);
        end
    end

    assign bus.ack  = ack_p1;
    assign bus.nack = nack_p1;
    assign cuenta   = cuenta_p1;
    assign lleno    = (cuenta_p1 == CW'(CANALES));

endmodule
